// File: rtl/fc_sequencer_if.sv
// rtl/fc_sequencer_if.sv - signal bundle between the fc sequencer, its requester and its fc
//
// Groups three channels:
//   s_*  : input transaction stream (s_valid/s_ready, s_fin, s_bin, s_train)
//   m_*  : result stream (m_valid/m_ready, m_fout, m_bout, m_err, m_cycles)
//   fc   : fd_prop/bk_prop, fin/bin towards fc; fd_prop_done/bk_prop_done, fout/bout back
// Modports:
//   slave  - the sequencer itself
//   master - the environment: requester, result consumer and the attached fc
interface fc_sequencer_if #(
    parameter int N  = 27,
    parameter int CW = 16
) ();
    logic          s_valid;
    logic          s_ready;
    logic [N-1:0]  s_fin;
    logic [N-1:0]  s_bin;
    logic          s_train;

    logic          m_valid;
    logic          m_ready;
    logic [N-1:0]  m_fout;
    logic [N-1:0]  m_bout;
    logic          m_err;
    logic [CW-1:0] m_cycles;

    logic          fd_prop;
    logic          bk_prop;
    logic [N-1:0]  fin;
    logic [N-1:0]  bin;
    logic          fd_prop_done;
    logic          bk_prop_done;
    logic [N-1:0]  fout;
    logic [N-1:0]  bout;

    modport slave (
        input  s_valid, s_fin, s_bin, s_train,
        output s_ready,
        output m_valid, m_fout, m_bout, m_err, m_cycles,
        input  m_ready,
        output fd_prop, bk_prop, fin, bin,
        input  fd_prop_done, bk_prop_done, fout, bout
    );

    modport master (
        output s_valid, s_fin, s_bin, s_train,
        input  s_ready,
        input  m_valid, m_fout, m_bout, m_err, m_cycles,
        output m_ready,
        input  fd_prop, bk_prop, fin, bin,
        output fd_prop_done, bk_prop_done, fout, bout
    );
endinterface

// File: rtl/fc_sequencer.sv
// rtl/fc_sequencer.sv - initiator for the fc fd_prop/bk_prop protocol
//
// Accepts one transaction at a time on the s_* stream, pulses fd_prop for one cycle, waits
// for fd_prop_done (bounded by TIMEOUT), optionally pulses bk_prop and waits for
// bk_prop_done, then presents the captured results on the m_* stream.
// Ports:
//   clk_in  - clock
//   rst_in  - asynchronous active-low reset
//   bus     - fc_sequencer_if.slave: s_* input stream, m_* result stream, fc handshake
// Parameters:
//   N       - vector width (must match the attached fc)
//   TIMEOUT - maximum WAIT cycles per pass before abort (>= 1)
//   CW      - width of the saturating m_cycles counter
module fc_sequencer #(
    parameter int N       = 27,
    parameter int TIMEOUT = 64,
    parameter int CW      = 16
) (
    input  logic          clk_in,
    input  logic          rst_in,
    fc_sequencer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FWD_PULSE = 3'd1;
    localparam logic [2:0] S_FWD_WAIT  = 3'd2;
    localparam logic [2:0] S_BK_PULSE  = 3'd3;
    localparam logic [2:0] S_BK_WAIT   = 3'd4;
    localparam logic [2:0] S_OUT       = 3'd5;

    logic [2:0]    state;
    // Held low through reset and set on the first edge after release, so s_ready stays 0
    // while in reset even though the reset state is IDLE.
    logic          armed;
    logic [TW-1:0] timer;
    logic [N-1:0]  fin_q;
    logic [N-1:0]  bin_q;
    logic          train_q;
    logic [N-1:0]  fout_q;
    logic [N-1:0]  bout_q;
    logic          err_q;
    logic [CW-1:0] cycles_q;

    logic          counting;
    logic          last_wait;

    assign counting  = (state == S_FWD_PULSE) || (state == S_FWD_WAIT) ||
                       (state == S_BK_PULSE)  || (state == S_BK_WAIT);
    // timer is 0 in the first WAIT cycle, so TIMEOUT-1 marks the TIMEOUT-th WAIT cycle;
    // a done arriving in that same cycle still wins over the abort.
    assign last_wait = (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= S_IDLE;
            armed    <= 1'b0;
            timer    <= '0;
            fin_q    <= '0;
            bin_q    <= '0;
            train_q  <= 1'b0;
            fout_q   <= '0;
            bout_q   <= '0;
            err_q    <= 1'b0;
            cycles_q <= '0;
        end else begin
            armed <= 1'b1;

            if (counting && (cycles_q != {CW{1'b1}})) begin
                cycles_q <= cycles_q + CW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (bus.s_valid && armed) begin
                        fin_q    <= bus.s_fin;
                        bin_q    <= bus.s_bin;
                        train_q  <= bus.s_train;
                        fout_q   <= '0;
                        bout_q   <= '0;
                        err_q    <= 1'b0;
                        cycles_q <= '0;
                        state    <= S_FWD_PULSE;
                    end
                end
                S_FWD_PULSE: begin
                    timer <= '0;
                    state <= S_FWD_WAIT;
                end
                S_FWD_WAIT: begin
                    timer <= timer + TW'(1);
                    if (bus.fd_prop_done) begin
                        fout_q <= bus.fout;
                        state  <= train_q ? S_BK_PULSE : S_OUT;
                    end else if (last_wait) begin
                        err_q  <= 1'b1;
                        fout_q <= '0;
                        state  <= S_OUT;
                    end
                end
                S_BK_PULSE: begin
                    timer <= '0;
                    state <= S_BK_WAIT;
                end
                S_BK_WAIT: begin
                    timer <= timer + TW'(1);
                    if (bus.bk_prop_done) begin
                        bout_q <= bus.bout;
                        state  <= S_OUT;
                    end else if (last_wait) begin
                        err_q  <= 1'b1;
                        bout_q <= '0;
                        state  <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.m_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.s_ready  = armed && (state == S_IDLE);
    assign bus.fd_prop  = (state == S_FWD_PULSE);
    assign bus.bk_prop  = (state == S_BK_PULSE);
    assign bus.fin      = fin_q;
    assign bus.bin      = bin_q;
    assign bus.m_valid  = (state == S_OUT);
    assign bus.m_fout   = fout_q;
    assign bus.m_bout   = bout_q;
    assign bus.m_err    = err_q;
    assign bus.m_cycles = cycles_q;
endmodule

// File: tb/tb_fc_sequencer.sv
// tb/tb_fc_sequencer.sv - scoreboard bench for fc_sequencer with a 3-cycle stub fc
module tb_fc_sequencer;
    localparam int N  = 27;
    localparam int CW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fc_sequencer_if #(.N(N), .CW(CW)) bus ();

    fc_sequencer #(.N(N), .TIMEOUT(64), .CW(CW)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    // Stub fc: done = prop delayed 3 cycles; not reset, so a late done can follow a reset.
    logic [2:0]   fd_sr  = '0;
    logic [2:0]   bk_sr  = '0;
    logic         fd_en  = 1'b1;
    logic         inj_fd = 1'b0;
    logic [N-1:0] stub_fout = '0;
    logic [N-1:0] stub_bout = '0;

    always @(posedge clk) begin
        fd_sr <= {fd_sr[1:0], bus.fd_prop};
        bk_sr <= {bk_sr[1:0], bus.bk_prop};
    end
    assign bus.fd_prop_done = (fd_sr[2] & fd_en) | inj_fd;
    assign bus.bk_prop_done = bk_sr[2];
    assign bus.fout         = stub_fout;
    assign bus.bout         = stub_bout;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0]  fout;
        logic [N-1:0]  bout;
        logic          err;
        logic [CW-1:0] cyc;
        int            nfd;
        int            nbk;
    } exp_t;

    exp_t q[$];

    task automatic push_exp(input logic [N-1:0] f, input logic [N-1:0] b, input logic e,
                            input logic [CW-1:0] c, input int nf, input int nb);
        exp_t x;
        x.fout = f; x.bout = b; x.err = e; x.cyc = c; x.nfd = nf; x.nbk = nb;
        q.push_back(x);
    endtask

    // Monitor: counts prop pulses per transaction and checks every result handshake.
    int nfd = 0;
    int nbk = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            if (bus.s_valid && bus.s_ready) begin
                nfd = 0;
                nbk = 0;
            end
            if (bus.fd_prop) nfd++;
            if (bus.bk_prop) nbk++;
            if (bus.fd_prop && bus.bk_prop) chk("prop_overlap", 1, 0);
            if (bus.m_valid && bus.m_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("m_fout",   bus.m_fout,   e.fout);
                    chk("m_bout",   bus.m_bout,   e.bout);
                    chk("m_err",    bus.m_err,    e.err);
                    chk("m_cycles", bus.m_cycles, e.cyc);
                    chk("fd_pulses", nfd, e.nfd);
                    chk("bk_pulses", nbk, e.nbk);
                end
            end
        end
    end

    task automatic send(input logic [N-1:0] f, input logic [N-1:0] b, input logic t);
        int n = 0;
        bus.s_fin   = f;
        bus.s_bin   = b;
        bus.s_train = t;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("accept_timeout", 1, 0);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.s_valid = 1'b0;
        bus.s_fin   = '0;
        bus.s_bin   = '0;
        bus.s_train = 1'b0;
        bus.m_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready",  bus.s_ready, 0);
        chk("rst_m_valid",  bus.m_valid, 0);
        chk("rst_props",    {bus.fd_prop, bus.bk_prop}, 0);
        chk("rst_fin_bin",  {bus.fin, bus.bin}, 0);
        chk("rst_m_data",   {bus.m_fout, bus.m_bout, bus.m_err}, 0);
        chk("rst_m_cycles", bus.m_cycles, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_s_ready_low", bus.s_ready, 0);
        @(posedge clk); #1;
        chk("rel_s_ready_high", bus.s_ready, 1);

        // 1: forward only
        stub_fout = 27'h7654321;
        stub_bout = 27'h0ABCDEF;
        push_exp(27'h7654321, 27'h0, 1'b0, 16'd4, 1, 0);
        send(27'h1234567, 27'h0111111, 1'b0);
        chk("fin_hold", bus.fin, 27'h1234567);
        chk("s_ready_busy", bus.s_ready, 0);
        drain();

        // 2: forward + backward
        push_exp(27'h7654321, 27'h0ABCDEF, 1'b0, 16'd8, 1, 1);
        send(27'h0000042, 27'h2222222, 1'b1);
        chk("bin_hold", bus.bin, 27'h2222222);
        drain();

        // 3: back-pressure in OUT with a pending s_valid
        bus.m_ready = 1'b0;
        push_exp(27'h7654321, 27'h0, 1'b0, 16'd4, 1, 0);
        send(27'h0000ABC, 27'h0, 1'b0);
        n = 0;
        while (!bus.m_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_m_valid", bus.m_valid, 1);
        bus.s_fin   = 27'h0000DEF;
        bus.s_train = 1'b0;
        bus.s_valid = 1'b1;
        push_exp(27'h7654321, 27'h0, 1'b0, 16'd4, 1, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid",  bus.m_valid, 1);
            chk("bp_hold_fout",   bus.m_fout, 27'h7654321);
            chk("bp_hold_cycles", bus.m_cycles, 16'd4);
            chk("bp_s_ready",     bus.s_ready, 0);
        end
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_s_ready", bus.s_ready, 1);
        chk("bp_idle_m_valid", bus.m_valid, 0);
        @(posedge clk); #1;
        chk("bp_next_fd_prop", bus.fd_prop, 1);
        chk("bp_next_fin",     bus.fin, 27'h0000DEF);
        bus.s_valid = 1'b0;
        drain();

        // 4: forward timeout, train set but no backward pass
        fd_en = 1'b0;
        push_exp(27'h0, 27'h0, 1'b1, 16'd65, 1, 0);
        send(27'h1555555, 27'h0AAAAAA, 1'b1);
        drain();
        fd_en = 1'b1;

        // 5: reset in FWD_WAIT, late done ignored
        send(27'h0333333, 27'h0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_fd_prop", bus.fd_prop, 0);
        chk("mid_rst_s_ready", bus.s_ready, 0);
        chk("mid_rst_m_valid", bus.m_valid, 0);
        chk("mid_rst_fin",     bus.fin, 0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("mid_rel_s_ready_low", bus.s_ready, 0);
        @(posedge clk); #1;
        chk("mid_rel_s_ready_high", bus.s_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("late_done_m_valid", bus.m_valid, 0);
        chk("late_done_s_ready", bus.s_ready, 1);

        // 6: spurious done in IDLE and in the FWD_PULSE cycle
        inj_fd = 1'b1;
        @(posedge clk); #1;
        inj_fd = 1'b0;
        chk("spur_idle_m_valid", bus.m_valid, 0);
        push_exp(27'h7654321, 27'h0, 1'b0, 16'd4, 1, 0);
        send(27'h0777777, 27'h0, 1'b0);
        chk("spur_pulse_fd_prop", bus.fd_prop, 1);
        inj_fd = 1'b1;
        @(posedge clk); #1;
        inj_fd = 1'b0;
        drain();

        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
